// File: rtl/intmul_result_queue.sv
// Result FIFO behind the pipelined integer multiplier: captures products on commit,
// hands them out over valid/ready, and issues credits so no commit is ever dropped.
// Optional error checking is enabled with `define INTMUL_RESQ_ERRCHK_EN (adds port err).
module intmul_result_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_val,
  input  logic          issue_rdy,
  input  logic          commit,
  input  logic [DW-1:0] longP,
  output logic          issue_ok,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] inflight
`ifdef INTMUL_RESQ_ERRCHK_EN
  ,
  output logic          err
`endif
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: an entry leaves when out_val && out_rdy at a rising edge; out_data is
  // held while out_val && !out_rdy. Upstream may start an op only while issue_ok is 1.

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, inflight_q;
  logic [CW:0]   credit_sum;
  logic          full, issue_evt, pop, push, inf_inc, inf_dec;

  assign full       = (count_q == CW'(DEPTH));
  assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
  assign issue_ok   = (credit_sum < (CW+1)'(DEPTH));
  assign issue_evt  = issue_val & issue_rdy & issue_ok;
  assign out_val    = (count_q != '0);
  assign pop        = out_val & out_rdy;
  // A commit into a full queue with no same-cycle pop is dropped (saturation).
  assign push       = commit & (~full | pop);
  assign inf_inc    = issue_evt & ~commit;
  // Commit with nothing in flight saturates at zero rather than wrapping.
  assign inf_dec    = commit & ~issue_evt & (inflight_q != '0);

  assign out_data = out_val ? mem[rd_ptr] : '0;
  assign count    = count_q;
  assign inflight = inflight_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= longP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (inf_inc)      inflight_q <= inflight_q + CW'(1);
      else if (inf_dec) inflight_q <= inflight_q - CW'(1);
    end
  end

`ifdef INTMUL_RESQ_ERRCHK_EN
  logic err_drop, err_orphan, err_credit;

  assign err_drop   = commit & full & ~pop;
  assign err_orphan = commit & (inflight_q == '0);
  // Unreachable when upstream gates val_op with issue_ok; catches wiring errors.
  assign err_credit = issue_val & issue_rdy & ~issue_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (err_drop | err_orphan | err_credit) begin
      err <= 1'b1;
`ifndef SYNTHESIS
      $display("intmul_result_queue error at %0t: drop=%0b orphan=%0b credit=%0b",
               $time, err_drop, err_orphan, err_credit);
`endif
    end
  end
`endif

endmodule

// File: doc/intmul_result_queue.md
Name: intmul_result_queue

Overview:
- Downstream stage of the pipelined integer multiplier.
- Captures each 64-bit product on the multiplier's one-cycle `commit` pulse. The multiplier has no backpressure, so the product must be taken that cycle.
- Buffers products in a circular FIFO and presents them to the consumer over a valid/ready handshake.
- Tracks issued-but-uncommitted operations and drives a credit signal. Upstream uses it to gate `val_op`, so a result is never dropped.

Parameters:
- DEPTH, 4, number of result entries; power of two, minimum 2.
- DW, 64, product width; matches multiplier `longP`.
- CW, 3, counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- issue_val  in  1  tap of multiplier `val_op`.
- issue_rdy  in  1  tap of multiplier `oprand_rdy`.
- commit  in  1  multiplier result-valid pulse.
- longP  in  DW  multiplier product; sampled only when `commit`=1.
- issue_ok  out  1  credit available; upstream ANDs it into `val_op`.
- out_val  out  1  head entry valid.
- out_rdy  in  1  consumer accepts head.
- out_data  out  DW  head entry data.
- count  out  CW  current FIFO occupancy.
- inflight  out  CW  operations accepted by the multiplier but not yet committed.

Behaviour:
- Reset (reset=0 at clk edge):
  - rd_ptr, wr_ptr, count, inflight <- 0.
  - out_val=0, out_data=0, issue_ok=1.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all entries and credits. The multiplier is reset by the same system reset.
- Events:
  - Issue event I = issue_val & issue_rdy & issue_ok.
  - Push event P = commit.
  - Pop event Q = out_val & out_rdy.
- Counter updates:
  - inflight_next = inflight + I - P.
  - count_next = count + P - Q.
  - Simultaneous I and P leave inflight unchanged.
  - Simultaneous P and Q leave count unchanged, also when full or empty.
- Push: mem[wr_ptr] <- longP; wr_ptr advances by 1, wrapping from DEPTH-1 to 0.
- Pop: rd_ptr advances by 1 with the same wrap rule.
- Outputs:
  - out_val = (count != 0), registered-state derived.
  - out_data = mem[rd_ptr].
  - No combinational bypass: a product committed at edge N is visible at out_val/out_data after edge N, i.e. 1-cycle latency.
  - out_data is held stable while out_val=1 and out_rdy=0.
  - Results leave in commit order; the multiplier commits in issue order.
- Credit: issue_ok = (inflight + count) < DEPTH, combinational from registered counters.
  - Every accepted operation is guaranteed a free entry at commit time.
  - A pop in the current cycle does not raise issue_ok until the next cycle (no ready-path from out_rdy).
- Boundaries:
  - Commit while count==DEPTH and no pop, or commit while inflight==0, is illegal. Protocol guarantees it never happens.
  - On an illegal commit: no pointer or count update beyond saturation. The write is dropped, count holds at DEPTH, and inflight holds at 0.
- State machine: none beyond the counters. Internal pointer width is log2(DEPTH).

Optional Feature:
- Macro: INTMUL_RESQ_ERRCHK_EN.
- When defined:
  - Adds output port `err`, 1-bit sticky, cleared by reset.
  - err sets on a dropped commit (full without same-cycle pop).
  - err sets on commit with inflight==0.
  - err sets on issue event while issue_ok=0; this term is unreachable by construction but checked for wiring errors.
  - Simulation builds also `$display` a message with the simulation time at each error.
- When undefined: port absent, no checking logic. Illegal cases behave as the saturation rules above.

Test Plan:
- Reset then single op: issue 3*5 with out_rdy=1 -> after commit, out_val=1 one cycle later with out_data=15; count returns 0; inflight 0->1->0.
- Back-to-back fill with out_rdy=0 and DEPTH=4: issue products 1,2,3,4 -> issue_ok drops to 0 once inflight+count=4; 5th operand held; count=4.
- Drain after fill: raise out_rdy -> out_data sequence 1,2,3,4 in order; issue_ok returns to 1 one cycle after the first pop.
- Simultaneous push/pop at full: count=4, commit 0xFFFFFFFE00000001 in the same cycle as a pop -> count stays 4; new entry is last out; no error.
- Pointer wrap: 10 ops with out_rdy toggling 1,0,1,0 -> all 10 products out in order, e.g. 0xFFFFFFFF*0xFFFFFFFF=0xFFFFFFFE00000001; count never exceeds 4.
- Reset mid-stream: assert reset low with count=3, inflight=1 -> next cycle out_val=0, count=0, inflight=0, issue_ok=1. With INTMUL_RESQ_ERRCHK_EN, a forced commit while full and no pop -> err=1 and stays 1 until reset.
